// File: rtl/fft_output_serializer.sv
// Ping-pong frame buffer: takes a whole FFT frame per handshake and replays it
// one bin per handshake with bin index and end-of-frame flag.
`timescale 1ns/1ps

module fft_ser_word #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_we,
  input  logic                      i_bank,
  input  logic [BIT_WIDTH-1:0]      i_d,
  output logic [1:0][BIT_WIDTH-1:0] o_q
);
  logic [1:0][BIT_WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_q         <= '0;
    else if (i_we) r_q[i_bank] <= i_d;
  end

  assign o_q = r_q;
endmodule

module fft_output_serializer #(
  parameter int BIT_WIDTH   = 32,
  parameter int N_SAMPLES   = 8,
  parameter int OUTPUT_HALF = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BIT_WIDTH-1:0]         recv_msg [N_SAMPLES-1:0],
  input  logic                         recv_val,
  output logic                         recv_rdy,
  output logic [BIT_WIDTH-1:0]         send_msg,
  output logic [$clog2(N_SAMPLES)-1:0] send_idx,
  output logic                         send_last,
  output logic                         send_val,
  input  logic                         send_rdy
);
  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam int N_OUT = (OUTPUT_HALF != 0) ? (N_SAMPLES/2 + 1) : N_SAMPLES;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OUT - 1);

  logic [N_SAMPLES-1:0][1:0][BIT_WIDTH-1:0] w_word;
  logic             r_wr_bank, r_rd_bank;
  logic [1:0]       r_full_cnt;
  logic [IDX_W-1:0] r_rd_idx;
  logic             w_accept, w_fire, w_release;
  logic             w_wr_bank_nx, w_rd_bank_nx;
  logic [1:0]       w_full_cnt_nx;
  logic [IDX_W-1:0] w_rd_idx_nx;

  // One word slice per bin; each slice holds that bin for both banks.
  for (genvar g = 0; g < N_SAMPLES; g++) begin : g_word
    fft_ser_word #(.BIT_WIDTH(BIT_WIDTH)) u_word (
      .clk    (clk),
      .reset  (reset),
      .i_we   (w_accept),
      .i_bank (r_wr_bank),
      .i_d    (recv_msg[g]),
      .o_q    (w_word[g])
    );
  end

  assign recv_rdy  = (r_full_cnt != 2'd2);
  assign send_val  = (r_full_cnt != 2'd0);
  assign send_msg  = w_word[r_rd_idx][r_rd_bank];
  assign send_idx  = r_rd_idx;
  assign send_last = (r_rd_idx == LAST);

  assign w_accept  = recv_val && recv_rdy;
  assign w_fire    = send_val && send_rdy;
  assign w_release = w_fire && send_last;

  always_comb begin
    w_wr_bank_nx  = r_wr_bank;
    w_rd_bank_nx  = r_rd_bank;
    w_rd_idx_nx   = r_rd_idx;
    w_full_cnt_nx = r_full_cnt;
    if (w_accept) w_wr_bank_nx = ~r_wr_bank;
    if (w_fire) begin
      if (send_last) begin
        w_rd_idx_nx  = '0;
        w_rd_bank_nx = ~r_rd_bank;
      end else begin
        w_rd_idx_nx = r_rd_idx + IDX_W'(1);
      end
    end
    // Accept and release in the same cycle leave occupancy unchanged.
    case ({w_accept, w_release})
      2'b10:   w_full_cnt_nx = r_full_cnt + 2'd1;
      2'b01:   w_full_cnt_nx = r_full_cnt - 2'd1;
      default: w_full_cnt_nx = r_full_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_rd_idx   <= '0;
      r_full_cnt <= 2'd0;
    end else begin
      r_wr_bank  <= w_wr_bank_nx;
      r_rd_bank  <= w_rd_bank_nx;
      r_rd_idx   <= w_rd_idx_nx;
      r_full_cnt <= w_full_cnt_nx;
    end
  end
endmodule

// File: tb/tb_fft_output_serializer.sv
// Scoreboard bench: three serializer configurations (8 bins, 8 bins half, 16 bins).
`timescale 1ns/1ps

module tb_fft_output_serializer;
  typedef struct {
    logic [31:0] v;
    int          idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] rv, sr;
  logic [31:0] m8 [7:0];
  logic [31:0] mh [7:0];
  logic [31:0] m16 [15:0];
  wire  [2:0] rr, sv, slast;
  wire  [2:0][31:0] smsg;
  wire  [2:0] ia, ib;
  wire  [3:0] ic;

  exp_t q [3][$];
  int   held [3];
  logic pv [3], ps [3], plast [3];
  logic [31:0] pmsg [3];
  logic [3:0]  pidx [3];
  int   acc_cyc [$];
  int   last_cyc [$];
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  logic c_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_output_serializer #(.BIT_WIDTH(32), .N_SAMPLES(8), .OUTPUT_HALF(0)) u_a (
    .clk(clk), .reset(reset), .recv_msg(m8), .recv_val(rv[0]), .recv_rdy(rr[0]),
    .send_msg(smsg[0]), .send_idx(ia), .send_last(slast[0]), .send_val(sv[0]), .send_rdy(sr[0]));
  fft_output_serializer #(.BIT_WIDTH(32), .N_SAMPLES(8), .OUTPUT_HALF(1)) u_b (
    .clk(clk), .reset(reset), .recv_msg(mh), .recv_val(rv[1]), .recv_rdy(rr[1]),
    .send_msg(smsg[1]), .send_idx(ib), .send_last(slast[1]), .send_val(sv[1]), .send_rdy(sr[1]));
  fft_output_serializer #(.BIT_WIDTH(32), .N_SAMPLES(16), .OUTPUT_HALF(0)) u_c (
    .clk(clk), .reset(reset), .recv_msg(m16), .recv_val(rv[2]), .recv_rdy(rr[2]),
    .send_msg(smsg[2]), .send_idx(ic), .send_last(slast[2]), .send_val(sv[2]), .send_rdy(sr[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [3:0] idx_of(input int d);
    case (d)
      0:       return {1'b0, ia};
      1:       return {1'b0, ib};
      default: return ic;
    endcase
  endfunction

  function automatic logic [31:0] in_word(input int d, input int i);
    case (d)
      0:       return m8[i[2:0]];
      1:       return mh[i[2:0]];
      default: return m16[i[3:0]];
    endcase
  endfunction

  // Model: a frame in flight is just the list of bins it will emit.
  task automatic mon(input int d);
    int   nout;
    exp_t e;
    nout = (d == 0) ? 8 : (d == 1) ? 5 : 16;
    chk($sformatf("send_val[%0d]", d), {31'd0, sv[d]}, {31'd0, held[d] > 0});
    chk($sformatf("recv_rdy[%0d]", d), {31'd0, rr[d]}, {31'd0, held[d] < 2});
    if (pv[d] && !ps[d]) begin
      chk($sformatf("stall_msg[%0d]", d), smsg[d], pmsg[d]);
      chk($sformatf("stall_idx[%0d]", d), {28'd0, idx_of(d)}, {28'd0, pidx[d]});
      chk($sformatf("stall_last[%0d]", d), {31'd0, slast[d]}, {31'd0, plast[d]});
    end
    if (sv[d] && sr[d]) begin
      if (q[d].size() == 0) begin
        fail_now($sformatf("unexpected_bin[%0d]: actual=bin %0d required=no bin", d, idx_of(d)));
      end else begin
        e = q[d].pop_front();
        chk($sformatf("bin_msg[%0d]", d), smsg[d], e.v);
        chk($sformatf("bin_idx[%0d]", d), {28'd0, idx_of(d)}, e.idx);
        chk($sformatf("bin_last[%0d]", d), {31'd0, slast[d]}, {31'd0, e.last});
        if (e.last) begin
          held[d]--;
          if (d == 0) last_cyc.push_back(cyc);
        end
      end
    end
    if (rv[d] && rr[d]) begin
      for (int i = 0; i < nout; i++) begin
        e.v    = in_word(d, i);
        e.idx  = i;
        e.last = (i == nout - 1);
        q[d].push_back(e);
      end
      held[d]++;
      if (d == 0) acc_cyc.push_back(cyc);
    end
    pv[d]    = sv[d];
    ps[d]    = sr[d];
    pmsg[d]  = smsg[d];
    pidx[d]  = idx_of(d);
    plast[d] = slast[d];
  endtask

  always @(negedge clk) begin
    if (!reset) for (int d = 0; d < 3; d++) mon(d);
  end

  task automatic drive_frame(input int d, input logic [31:0] f [16]);
    bit ok;
    for (int i = 0; i < 16; i++) begin
      if (d == 0 && i < 8) m8[i] = f[i];
      if (d == 1 && i < 8) mh[i] = f[i];
      if (d == 2)          m16[i] = f[i];
    end
    rv[d] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (rr[d]) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    rv[d] = 1'b0;
    if (!ok) fail_now($sformatf("accept_timeout[%0d]", d));
  endtask

  task automatic drain(input int d);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (q[d].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now($sformatf("drain_timeout[%0d]", d));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f  [16];
    logic [31:0] f2 [16];
    logic [31:0] f3 [16];
    reset = 1'b1;
    rv = '0;
    sr = '0;
    c_done = 1'b0;
    for (int d = 0; d < 3; d++) begin
      held[d] = 0; pv[d] = 1'b0; ps[d] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin m8[i] = '0; mh[i] = '0; end
      m16[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    repeat (10) begin
      @(negedge clk);
      chk("idle_msg", smsg[0], 32'd0);
      chk("idle_idx", {29'd0, ia}, 32'd0);
      chk("idle_last", {31'd0, slast[0]}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Single full frame, 8 bins
    sr = 3'b111;
    f[0] = 32'h0001_0000;
    for (int i = 1; i < 16; i++) f[i] = i;
    drive_frame(0, f);
    drain(0);

    // Half-spectrum: only bins 0..4
    for (int i = 0; i < 16; i++) f[i] = 10 + i;
    drive_frame(1, f);
    drain(1);

    // Three frames back-to-back into a stalled sink
    acc_cyc.delete();
    last_cyc.delete();
    sr[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      f[i] = 32'h100 + i; f2[i] = 32'h200 + i; f3[i] = 32'h300 + i;
    end
    fork
      begin
        drive_frame(0, f);
        drive_frame(0, f2);
        drive_frame(0, f3);
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        chk("stall_full_recv_rdy", {31'd0, rr[0]}, 32'd0);
        chk("stall_full_send_val", {31'd0, sv[0]}, 32'd1);
        sr[0] = 1'b1;
      end
    join
    drain(0);
    if (acc_cyc.size() == 3 && last_cyc.size() >= 1)
      chk("frame3_accept_cycle", acc_cyc[2], last_cyc[0] + 1);
    else
      fail_now($sformatf("frame3_accept_count: actual=%0d/%0d required=3/>=1",
                         acc_cyc.size(), last_cyc.size()));

    // Accept on the same edge as the last bin of the only held frame
    for (int i = 0; i < 16; i++) begin
      f[i] = 32'hA000 + i; f2[i] = 32'hB000 + i;
    end
    drive_frame(0, f);
    for (int t = 0; t < 20 && ia != 3'd7; t++) begin
      @(posedge clk);
      #1;
    end
    chk("simul_pre_last", {31'd0, slast[0]}, 32'd1);
    for (int i = 0; i < 8; i++) m8[i] = f2[i];
    rv[0] = 1'b1;
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
    chk("simul_send_val", {31'd0, sv[0]}, 32'd1);
    chk("simul_recv_rdy", {31'd0, rr[0]}, 32'd1);
    chk("simul_idx", {29'd0, ia}, 32'd0);
    chk("simul_msg", smsg[0], f2[0]);
    drain(0);

    // Random back-pressure, 200 frames of 16 bins
    fork
      begin
        while (!c_done) begin
          @(posedge clk);
          #1;
          sr[2] = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 16; i++) f[i] = $urandom;
      drive_frame(2, f);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    drain(2);
    c_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sr[2] = 1'b1;

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 16; i++) f[i] = 32'hC0DE_0000 + i;
    drive_frame(2, f);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_send_val[%0d]", d), {31'd0, sv[d]}, 32'd0);
      chk($sformatf("rst_recv_rdy[%0d]", d), {31'd0, rr[d]}, 32'd1);
    end
    chk("rst_msg", smsg[2], 32'd0);
    chk("rst_idx", {28'd0, ic}, 32'd0);
    for (int d = 0; d < 3; d++) begin
      q[d].delete(); held[d] = 0; pv[d] = 1'b0;
    end
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Recovery after reset
    for (int i = 0; i < 16; i++) f[i] = 32'h5A5A_0000 + i;
    drive_frame(2, f);
    drain(2);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
